// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: state encodings, iteration
// count and the HI/LO result slices also used by the multiplier packing.
package div_iter_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CYCLES = DIV_DATA_W;

  // {HI, LO} packing of a 2*DATA_W result: HI = remainder, LO = quotient.
  localparam int DIV_LO_LSB = 0;
  localparam int DIV_LO_MSB = DIV_DATA_W - 1;
  localparam int DIV_HI_LSB = DIV_DATA_W;
  localparam int DIV_HI_MSB = 2 * DIV_DATA_W - 1;

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'd0,
    DIV_STATE_BUSY = 2'd1,
    DIV_STATE_ZERO = 2'd2,
    DIV_STATE_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_iter_if.sv
// Request/result bundle between the execute stage (master) and the divider
// (slave).
interface div_iter_if
  import div_iter_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
);
  logic [DATA_W-1:0]   a_i;
  logic [DATA_W-1:0]   b_i;
  logic                sign_i;
  logic                start_i;
  logic                annul_i;
  logic                busy_o;
  logic                ready_o;
  logic [2*DATA_W-1:0] result_o;

  modport master (
    output a_i, b_i, sign_i, start_i, annul_i,
    input  busy_o, ready_o, result_o
  );

  modport slave (
    input  a_i, b_i, sign_i, start_i, annul_i,
    output busy_o, ready_o, result_o
  );
endinterface

// File: rtl/div_iter_abs.sv
// Conditional two's-complement negate; gives magnitudes of signed operands
// and restores the sign of quotient/remainder.
module div_iter_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] mag_o
);
  assign mag_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on
// operand magnitudes, sign fixup folded into the final step.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input logic       clk,
  input logic       rst,
  div_iter_if.slave bus
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_e          state_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   dvd_q;
  logic [DATA_W-1:0]   bmag_q;
  logic [DATA_W-1:0]   rem_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                sign_a_q;
  logic                sign_b_q;
  logic [2*DATA_W-1:0] result_q;

  // Index 0 = dividend, 1 = divisor.
  logic [1:0][DATA_W-1:0] op_raw;
  logic [1:0][DATA_W-1:0] op_mag;
  logic [1:0]             op_neg;

  assign op_raw[0] = bus.a_i;
  assign op_raw[1] = bus.b_i;
  assign op_neg[0] = bus.a_i[DATA_W-1] & bus.sign_i;
  assign op_neg[1] = bus.b_i[DATA_W-1] & bus.sign_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_op_abs
    div_iter_abs #(.W(DATA_W)) u_abs (
      .val_i (op_raw[gi]),
      .neg_i (op_neg[gi]),
      .mag_o (op_mag[gi])
    );
  end

  // The trial value is one bit wider than the divisor; the borrow out of the
  // subtraction is the inverted quotient bit.
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic              qbit;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] quo_step;

  assign trial    = {rem_q, dvd_q[DATA_W-1]};
  assign diff     = trial - {1'b0, bmag_q};
  assign qbit     = ~diff[DATA_W];
  assign rem_step = qbit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quo_step = {dvd_q[DATA_W-2:0], qbit};

  // Index 0 = quotient (sign of a^b), 1 = remainder (sign of the dividend).
  logic [1:0][DATA_W-1:0] fix_raw;
  logic [1:0][DATA_W-1:0] fix_mag;
  logic [1:0]             fix_neg;

  assign fix_raw[0] = quo_step;
  assign fix_raw[1] = rem_step;
  assign fix_neg[0] = sign_a_q ^ sign_b_q;
  assign fix_neg[1] = sign_a_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fix_abs
    div_iter_abs #(.W(DATA_W)) u_abs (
      .val_i (fix_raw[gi]),
      .neg_i (fix_neg[gi]),
      .mag_o (fix_mag[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_STATE_IDLE;
      a_q      <= '0;
      dvd_q    <= '0;
      bmag_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        DIV_STATE_IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            a_q <= bus.a_i;
            if (bus.b_i == '0) begin
              state_q <= DIV_STATE_ZERO;
            end else begin
              sign_a_q <= op_neg[0];
              sign_b_q <= op_neg[1];
              dvd_q    <= op_mag[0];
              bmag_q   <= op_mag[1];
              rem_q    <= '0;
              cnt_q    <= '0;
              state_q  <= DIV_STATE_BUSY;
            end
          end
        end
        DIV_STATE_BUSY: begin
          if (bus.annul_i) begin
            state_q <= DIV_STATE_IDLE;
          end else begin
            dvd_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              result_q <= {fix_mag[1], fix_mag[0]};
              state_q  <= DIV_STATE_DONE;
            end
          end
        end
        DIV_STATE_ZERO: begin
          if (bus.annul_i) begin
            state_q <= DIV_STATE_IDLE;
          end else begin
            result_q <= {a_q, {DATA_W{1'b1}}};
            state_q  <= DIV_STATE_DONE;
          end
        end
        DIV_STATE_DONE: state_q <= DIV_STATE_IDLE;
        default:        state_q <= DIV_STATE_IDLE;
      endcase
    end
  end

  assign bus.busy_o   = (state_q != DIV_STATE_IDLE);
  assign bus.ready_o  = (state_q == DIV_STATE_DONE);
  assign bus.result_o = result_q;

endmodule
